// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register-index/word types and the hardwired-zero index for the register file slice.
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode-stage bus; master = fetch/decode side (requests, writeback), slave = register file (operands, stall).
interface reg_file_sb_if;
    import rf_pkg::*;
    logic     rd_en_i;
    reg_idx_t rs_addr_i;
    reg_idx_t rt_addr_i;
    logic     issue_i;
    reg_idx_t issue_rd_i;
    logic     wr_en_i;
    reg_idx_t wr_addr_i;
    word_t    wr_data_i;
    word_t    rs_data_o;
    word_t    rt_data_o;
    logic     stall_o;
    modport master (
        output rd_en_i, rs_addr_i, rt_addr_i, issue_i, issue_rd_i, wr_en_i, wr_addr_i, wr_data_i,
        input  rs_data_o, rt_data_o, stall_o
    );
    modport slave (
        input  rd_en_i, rs_addr_i, rt_addr_i, issue_i, issue_rd_i, wr_en_i, wr_addr_i, wr_data_i,
        output rs_data_o, rt_data_o, stall_o
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write bitmap with RAW/WAW hazard detection.
// Ports: clk_i/rst_i clock and sync reset; rd_en_i, rs/rt_addr_i read request; issue_i/issue_rd_i issued destination;
// wr_en_i/wr_addr_i writeback; stall_o combinational hazard flag.
module reg_scoreboard
    import rf_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     rd_en_i,
    input  reg_idx_t rs_addr_i,
    input  reg_idx_t rt_addr_i,
    input  logic     issue_i,
    input  reg_idx_t issue_rd_i,
    input  logic     wr_en_i,
    input  reg_idx_t wr_addr_i,
    output logic     stall_o
);
    logic [NUM_REGS-1:0] pend;
    logic hz_rs, hz_rt, hz_rd, accept;

    // A writeback landing this cycle resolves the hazard on its index.
    assign hz_rs   = (rs_addr_i  != REG_ZERO) && pend[rs_addr_i]  && !(wr_en_i && wr_addr_i == rs_addr_i);
    assign hz_rt   = (rt_addr_i  != REG_ZERO) && pend[rt_addr_i]  && !(wr_en_i && wr_addr_i == rt_addr_i);
    assign hz_rd   = (issue_rd_i != REG_ZERO) && pend[issue_rd_i] && !(wr_en_i && wr_addr_i == issue_rd_i);
    assign stall_o = rd_en_i && (hz_rs || hz_rt || (issue_i && hz_rd));
    assign accept  = rd_en_i && !stall_o && !rst_i;

    // Set is applied after clear so a same-index issue keeps ownership of the register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            if (wr_en_i) pend[wr_addr_i] <= 1'b0;
            if (accept && issue_i && issue_rd_i != REG_ZERO) pend[issue_rd_i] <= 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: decode-stage register file with write-through bypass, registered operands and pending-write scoreboard.
// Ports: clk_i clock; rst_i sync active-high reset; bus (slave) carries read/issue requests, writeback and operand/stall outputs.
module reg_file_sb
    import rf_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    reg_file_sb_if.slave bus
);
    word_t regs [NUM_REGS];
    word_t rs_val, rt_val;
    logic  accept;

    // r0 reads as zero; otherwise a same-cycle writeback to the index is forwarded.
    assign rs_val = (bus.rs_addr_i == REG_ZERO) ? '0 :
                    (bus.wr_en_i && bus.wr_addr_i == bus.rs_addr_i) ? bus.wr_data_i : regs[bus.rs_addr_i];
    assign rt_val = (bus.rt_addr_i == REG_ZERO) ? '0 :
                    (bus.wr_en_i && bus.wr_addr_i == bus.rt_addr_i) ? bus.wr_data_i : regs[bus.rt_addr_i];
    assign accept = bus.rd_en_i && !bus.stall_o && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs <= '{default: '0};
        end else if (bus.wr_en_i && bus.wr_addr_i != REG_ZERO) begin
            regs[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rs_data_o <= '0;
            bus.rt_data_o <= '0;
        end else if (accept) begin
            bus.rs_data_o <= rs_val;
            bus.rt_data_o <= rt_val;
        end
    end

    reg_scoreboard u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_en_i    (bus.rd_en_i),
        .rs_addr_i  (bus.rs_addr_i),
        .rt_addr_i  (bus.rt_addr_i),
        .issue_i    (bus.issue_i),
        .issue_rd_i (bus.issue_rd_i),
        .wr_en_i    (bus.wr_en_i),
        .wr_addr_i  (bus.wr_addr_i),
        .stall_o    (bus.stall_o)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
module tb_reg_file_sb;
    import rf_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    reg_file_sb_if bus();

    reg_file_sb dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic rd, input reg_idx_t rs, input reg_idx_t rt, input logic iss,
                         input reg_idx_t ird, input logic we, input reg_idx_t wa, input word_t wd);
        bus.rd_en_i = rd; bus.rs_addr_i = rs; bus.rt_addr_i = rt;
        bus.issue_i = iss; bus.issue_rd_i = ird;
        bus.wr_en_i = we; bus.wr_addr_i = wa; bus.wr_data_i = wd;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 0, 1, 5, 1, 5, 32'hFFFF_0000);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.stall_o); end
            cyc();
        end
        rst = 1'b0;
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'h0) begin errors++; $display("FAIL reset_rs got=%h exp=0", bus.rs_data_o); end
        checks++; if (bus.rt_data_o !== 32'h0) begin errors++; $display("FAIL reset_rt got=%h exp=0", bus.rt_data_o); end
    endtask

    task automatic test_bypass();
        drive(1, 3, 0, 0, 0, 1, 3, 32'hDEAD_BEEF);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL bypass_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs got=%h exp=deadbeef", bus.rs_data_o); end
        checks++; if (bus.rt_data_o !== 32'h0) begin errors++; $display("FAIL bypass_rt got=%h exp=0", bus.rt_data_o); end
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        cyc();
        checks++; if (bus.rs_data_o !== 32'h0) begin errors++; $display("FAIL read3_rs got=%h exp=0", bus.rs_data_o); end
        checks++; if (bus.rt_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read3_rt got=%h exp=deadbeef", bus.rt_data_o); end
    endtask

    task automatic test_r0();
        drive(1, 0, 0, 1, 0, 1, 0, 32'h1234_5678);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL r0_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'h0) begin errors++; $display("FAIL r0_bypass_rs got=%h exp=0", bus.rs_data_o); end
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL r0_waw_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rt_data_o !== 32'h0) begin errors++; $display("FAIL r0_read_rt got=%h exp=0", bus.rt_data_o); end
    endtask

    task automatic test_raw();
        drive(1, 3, 3, 1, 7, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall got=%0b exp=1", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_hold_rs got=%h exp=deadbeef", bus.rs_data_o); end
        checks++; if (bus.rt_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_hold_rt got=%h exp=deadbeef", bus.rt_data_o); end
        drive(1, 7, 0, 0, 0, 1, 7, 32'hA5A5_A5A5);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL raw_resolve_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL raw_wb_rs got=%h exp=a5a5a5a5", bus.rs_data_o); end
        checks++; if (bus.rt_data_o !== 32'h0) begin errors++; $display("FAIL raw_wb_rt got=%h exp=0", bus.rt_data_o); end
        drive(1, 0, 7, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL raw_cleared_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rt_data_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL raw_reread_rt got=%h exp=a5a5a5a5", bus.rt_data_o); end
    endtask

    task automatic test_waw();
        drive(1, 0, 0, 1, 9, 0, 0, 0);
        cyc();
        drive(1, 0, 0, 1, 9, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0b exp=1", bus.stall_o); end
        drive(0, 9, 9, 1, 9, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL idle_stall got=%0b exp=0", bus.stall_o); end
        drive(1, 0, 0, 1, 9, 1, 9, 32'h1111_2222);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL waw_resolve_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        drive(1, 9, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL set_wins_stall got=%0b exp=1", bus.stall_o); end
        drive(1, 0, 9, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL set_wins_rt_stall got=%0b exp=1", bus.stall_o); end
        drive(1, 9, 0, 0, 0, 1, 9, 32'h3333_4444);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL waw_clear_stall got=%0b exp=0", bus.stall_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'h3333_4444) begin errors++; $display("FAIL waw_data_rs got=%h exp=33334444", bus.rs_data_o); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 0, 1, 4, 32'h0000_0044);
        cyc();
        drive(1, 4, 4, 1, 4, 0, 0, 0);
        cyc();
        checks++; if (bus.rs_data_o !== 32'h0000_0044) begin errors++; $display("FAIL mid_pre_rs got=%h exp=00000044", bus.rs_data_o); end
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%0b exp=1", bus.stall_o); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL mid_post_stall got=%0b exp=0", bus.stall_o); end
        checks++; if (bus.rs_data_o !== 32'h0) begin errors++; $display("FAIL mid_rst_rs got=%h exp=0", bus.rs_data_o); end
        cyc();
        checks++; if (bus.rs_data_o !== 32'h0) begin errors++; $display("FAIL mid_reg4_rs got=%h exp=0", bus.rs_data_o); end
        drive(0, 0, 0, 0, 0, 1, 4, 32'h0000_0055);
        cyc();
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        cyc();
        checks++; if (bus.rt_data_o !== 32'h0000_0055) begin errors++; $display("FAIL mid_rewrite_rt got=%h exp=00000055", bus.rt_data_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_bypass();
        test_r0();
        test_raw();
        test_waw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
